hazard_unit_mc: RTL and testbench
=================================

Name: hazard_unit_mc

Overview:
Parametrised next-generation hazard/forwarding unit for the 5-stage MIPS pipeline. It adds two sequential controllers to the existing combinational rules (M/W forwarding, load-use stall, branch stall):
- a syscall drain FSM that holds a syscall in Decode until no write to v0/a0 is pending;
- a multi-cycle mult/div (MDU) busy counter that stalls HI/LO consumers.
It also keeps a saturating stall-cycle counter.

Parameters:
REG_AW, 5, register address width
V0_ADDR, 2, syscall service-code register index
A0_ADDR, 4, syscall argument register index
MDU_LAT, 4, MDU busy cycles after issue (>=1)
CNT_W, 32, StallCount width

Ports:
clk  in  1  pipeline clock
rst_n  in  1  asynchronous active-low reset
SyscallD  in  1  syscall in Decode
BranchD  in  1  branch in Decode
MemtoRegE, RegWriteE  in  1 each  Execute-stage controls
MemtoRegM, RegWriteM  in  1 each  Memory-stage controls
RegWriteW  in  1  Writeback write enable
RsD, RtD, RsE, RtE  in  REG_AW each  source register indices
WriteRegE, WriteRegM, WriteRegW  in  REG_AW each  destination indices
MduStartE  in  1  mult/div in Execute (starts MDU)
MduUseD  in  1  mfhi/mflo/mult/div in Decode
CntClr  in  1  synchronous clear of StallCount
StallF, StallD, FlushE  out  1 each  pipeline control
ForwardAD, ForwardBD  out  1 each  M-to-D forward for the branch comparator
ForwardAE, ForwardBE  out  2 each  00 regfile, 01 W, 10 M
SyscallGo  out  1  one-cycle syscall execute strobe
MduBusy  out  1  MDU counter nonzero
StallCount  out  CNT_W  total stalled cycles

Behaviour:
Reset:
- One clock clk; reset is asynchronous and active-low on rst_n.
- Asserting rst_n forces: FSM to S_IDLE, mdu_cnt=0, StallCount=0.
- While rst_n=0: StallF/StallD/FlushE/SyscallGo/MduBusy=0. Forward outputs follow the combinational rules below.
- Reset mid-drain abandons the syscall with no SyscallGo.

Forwarding (combinational):
- Register 0 is never forwarded.
- ForwardAD = RsD!=0 && RsD==WriteRegM && RegWriteM. ForwardBD same with RtD.
- ForwardAE = 10 if RsE!=0 && RsE==WriteRegM && RegWriteM; else 01 if the same test holds against WriteRegW/RegWriteW; else 00. M wins when M and W both match. ForwardBE same with RtE.

Combinational stall terms:
- lwstall = MemtoRegE && RtE!=0 && (RtE==RsD || RtE==RtD).
- branchstall = BranchD && ((RegWriteE && WriteRegE!=0 && WriteRegE in {RsD,RtD}) || (MemtoRegM && WriteRegM!=0 && WriteRegM in {RsD,RtD})).
- syspend = any of E/M/W has RegWrite=1 and dest in {V0_ADDR, A0_ADDR}.
- mdustall = MduUseD && MduBusy.
- other = lwstall || branchstall || mdustall.

Syscall FSM:
- S_IDLE: sysstall = SyscallD. If SyscallD, next state is S_DRAIN if syspend, else S_GO.
- S_DRAIN: sysstall=1. Next state is S_GO when !syspend.
- S_GO: sysstall=0. SyscallGo = !other. Return to S_IDLE when !other; otherwise hold S_GO with SyscallGo=0.
- SyscallGo fires exactly once per syscall.
- Minimum latency: SyscallGo in the 2nd cycle the syscall sits in D.

MDU counter:
- mdu_cnt width is clog2(MDU_LAT+1).
- On MduStartE, load MDU_LAT (reloads if already busy). Otherwise decrement when nonzero.
- MduBusy = mdu_cnt!=0.

Outputs:
- StallF = lwstall || branchstall || sysstall || mdustall; StallD = StallF; FlushE = StallF.
- StallCount: CntClr → 0 (clear wins over increment); else +1 when StallF, saturating at all-ones.

Test Plan:
1. Load-use: MemtoRegE=1, RtE=8, RsD=8 → StallF=StallD=FlushE=1 for 1 cycle; StallCount 0→1. Same with RtE=0 → no stall.
2. Forward priority: RegWriteM=RegWriteW=1, WriteRegM=WriteRegW=RsE=9 → ForwardAE=10. Drop RegWriteM → 01. RsE=0 → 00.
3. Syscall drain: SyscallD=1 with RegWriteM=1, WriteRegM=2, advancing to W next cycle then clearing → stall 3 cycles, SyscallGo one pulse in cycle 4, FSM back to S_IDLE.
4. Syscall, nothing pending → stall 1 cycle, SyscallGo in cycle 2. Repeat with lwstall asserted in the S_GO cycle → SyscallGo delayed 1 cycle, still a single pulse.
5. MDU: MduStartE pulse, MDU_LAT=4, MduUseD held → MduBusy high 4 cycles and StallF high 4 cycles; second MduStartE at cycle 2 → busy extends to cycle 6.
6. Reset/counter: rst_n low while in S_DRAIN → state S_IDLE, no SyscallGo, StallCount=0. CntClr with StallF=1 → StallCount=0. CNT_W=4 with 20 stall cycles → StallCount holds 15.

Source files
------------

// File: rtl/hazard_unit_mc.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_unit_mc
//  Description : Hazard / forwarding unit for the 5-stage MIPS pipeline with a
//                syscall drain controller, a multi-cycle MDU busy counter and a
//                saturating stall-cycle counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module hazard_unit_mc #(
    parameter int REG_AW  = 5,
    parameter int V0_ADDR = 2,
    parameter int A0_ADDR = 4,
    parameter int MDU_LAT = 4,
    parameter int CNT_W   = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              SyscallD,
    input  logic              BranchD,
    input  logic              MemtoRegE,
    input  logic              RegWriteE,
    input  logic              MemtoRegM,
    input  logic              RegWriteM,
    input  logic              RegWriteW,
    input  logic [REG_AW-1:0] RsD,
    input  logic [REG_AW-1:0] RtD,
    input  logic [REG_AW-1:0] RsE,
    input  logic [REG_AW-1:0] RtE,
    input  logic [REG_AW-1:0] WriteRegE,
    input  logic [REG_AW-1:0] WriteRegM,
    input  logic [REG_AW-1:0] WriteRegW,
    input  logic              MduStartE,
    input  logic              MduUseD,
    input  logic              CntClr,
    output logic              StallF,
    output logic              StallD,
    output logic              FlushE,
    output logic              ForwardAD,
    output logic              ForwardBD,
    output logic [1:0]        ForwardAE,
    output logic [1:0]        ForwardBE,
    output logic              SyscallGo,
    output logic              MduBusy,
    output logic [CNT_W-1:0]  StallCount
);

    localparam int                 C_MDU_W    = $clog2(MDU_LAT + 1);
    localparam logic [C_MDU_W-1:0] C_MDU_LOAD = C_MDU_W'(MDU_LAT);
    localparam logic [REG_AW-1:0]  C_V0       = REG_AW'(V0_ADDR);
    localparam logic [REG_AW-1:0]  C_A0       = REG_AW'(A0_ADDR);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRAIN = 2'd1,
        S_GO    = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [C_MDU_W-1:0] r_mdu_cnt;
    logic [CNT_W-1:0]   r_stall_cnt;

    logic w_lwstall;
    logic w_branchstall;
    logic w_syspend;
    logic w_mdustall;
    logic w_other;
    logic w_sysstall;
    logic w_go;
    logic w_stall;

    // Forwarding paths; register 0 is hardwired and never forwarded, M beats W
    always_comb begin
        ForwardAD = (RsD != '0) && (RsD == WriteRegM) && RegWriteM;
        ForwardBD = (RtD != '0) && (RtD == WriteRegM) && RegWriteM;
        ForwardAE = 2'b00;
        if ((RsE != '0) && (RsE == WriteRegM) && RegWriteM)
            ForwardAE = 2'b10;
        else if ((RsE != '0) && (RsE == WriteRegW) && RegWriteW)
            ForwardAE = 2'b01;
        ForwardBE = 2'b00;
        if ((RtE != '0) && (RtE == WriteRegM) && RegWriteM)
            ForwardBE = 2'b10;
        else if ((RtE != '0) && (RtE == WriteRegW) && RegWriteW)
            ForwardBE = 2'b01;
    end

    // Combinational stall sources
    always_comb begin
        w_lwstall     = MemtoRegE && (RtE != '0) && ((RtE == RsD) || (RtE == RtD));
        w_branchstall = BranchD &&
                        ((RegWriteE && (WriteRegE != '0) &&
                          ((WriteRegE == RsD) || (WriteRegE == RtD))) ||
                         (MemtoRegM && (WriteRegM != '0) &&
                          ((WriteRegM == RsD) || (WriteRegM == RtD))));
        w_syspend     = (RegWriteE && ((WriteRegE == C_V0) || (WriteRegE == C_A0))) ||
                        (RegWriteM && ((WriteRegM == C_V0) || (WriteRegM == C_A0))) ||
                        (RegWriteW && ((WriteRegW == C_V0) || (WriteRegW == C_A0)));
        w_mdustall    = MduUseD && MduBusy;
        w_other       = w_lwstall || w_branchstall || w_mdustall;
    end

    // Syscall controller state register; reset abandons any syscall in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    // Syscall controller: wait for v0/a0 writers to drain, then strobe once
    always_comb begin
        w_state_nxt = r_state;
        w_sysstall  = 1'b0;
        w_go        = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_sysstall = SyscallD;
                if (SyscallD)
                    w_state_nxt = w_syspend ? S_DRAIN : S_GO;
            end
            S_DRAIN: begin
                w_sysstall = 1'b1;
                if (!w_syspend)
                    w_state_nxt = S_GO;
            end
            S_GO: begin
                w_go = !w_other;
                if (!w_other)
                    w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // MDU busy counter: (re)load on issue, count down to idle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_mdu_cnt <= '0;
        else if (MduStartE)
            r_mdu_cnt <= C_MDU_LOAD;
        else if (r_mdu_cnt != '0)
            r_mdu_cnt <= r_mdu_cnt - C_MDU_W'(1);
    end

    // Saturating stalled-cycle counter; clear has priority over counting
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_stall_cnt <= '0;
        else if (CntClr)
            r_stall_cnt <= '0;
        else if (w_stall && !(&r_stall_cnt))
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end

    // Pipeline control outputs, all held low while reset is asserted
    always_comb begin
        MduBusy    = (r_mdu_cnt != '0);
        w_stall    = rst_n && (w_lwstall || w_branchstall || w_sysstall || w_mdustall);
        StallF     = w_stall;
        StallD     = w_stall;
        FlushE     = w_stall;
        SyscallGo  = rst_n && w_go;
        StallCount = r_stall_cnt;
    end

endmodule
`default_nettype wire

// File: tb/tb_hazard_unit_mc.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hazard_unit_mc
//  Description : Directed self-checking bench for hazard_unit_mc.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_unit_mc;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       SyscallD, BranchD, MemtoRegE, RegWriteE, MemtoRegM, RegWriteM, RegWriteW;
    logic [4:0] RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW;
    logic       MduStartE, MduUseD, CntClr;
    logic       StallF, StallD, FlushE, ForwardAD, ForwardBD, SyscallGo, MduBusy;
    logic [1:0] ForwardAE, ForwardBE;
    logic [31:0] StallCount;
    logic       StallF4, StallD4, FlushE4, ForwardAD4, ForwardBD4, SyscallGo4, MduBusy4;
    logic [1:0] ForwardAE4, ForwardBE4;
    logic [3:0] StallCount4;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    hazard_unit_mc dut (
        .clk(clk), .rst_n(rst_n), .SyscallD(SyscallD), .BranchD(BranchD),
        .MemtoRegE(MemtoRegE), .RegWriteE(RegWriteE), .MemtoRegM(MemtoRegM),
        .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .RsD(RsD), .RtD(RtD),
        .RsE(RsE), .RtE(RtE), .WriteRegE(WriteRegE), .WriteRegM(WriteRegM),
        .WriteRegW(WriteRegW), .MduStartE(MduStartE), .MduUseD(MduUseD),
        .CntClr(CntClr), .StallF(StallF), .StallD(StallD), .FlushE(FlushE),
        .ForwardAD(ForwardAD), .ForwardBD(ForwardBD), .ForwardAE(ForwardAE),
        .ForwardBE(ForwardBE), .SyscallGo(SyscallGo), .MduBusy(MduBusy),
        .StallCount(StallCount)
    );

    hazard_unit_mc #(.CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .SyscallD(SyscallD), .BranchD(BranchD),
        .MemtoRegE(MemtoRegE), .RegWriteE(RegWriteE), .MemtoRegM(MemtoRegM),
        .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .RsD(RsD), .RtD(RtD),
        .RsE(RsE), .RtE(RtE), .WriteRegE(WriteRegE), .WriteRegM(WriteRegM),
        .WriteRegW(WriteRegW), .MduStartE(MduStartE), .MduUseD(MduUseD),
        .CntClr(CntClr), .StallF(StallF4), .StallD(StallD4), .FlushE(FlushE4),
        .ForwardAD(ForwardAD4), .ForwardBD(ForwardBD4), .ForwardAE(ForwardAE4),
        .ForwardBE(ForwardBE4), .SyscallGo(SyscallGo4), .MduBusy(MduBusy4),
        .StallCount(StallCount4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clr_in();
        SyscallD = 0; BranchD = 0; MemtoRegE = 0; RegWriteE = 0; MemtoRegM = 0;
        RegWriteM = 0; RegWriteW = 0; RsD = 0; RtD = 0; RsE = 0; RtE = 0;
        WriteRegE = 0; WriteRegM = 0; WriteRegW = 0; MduStartE = 0; MduUseD = 0;
        CntClr = 0;
    endtask

    // advance one clock; inputs are changed 1 time unit after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        clr_in();
        rst_n = 1'b0;
        // reset: stalls gated off, forwarding still live
        MemtoRegE = 1; RtE = 8; RsD = 8; WriteRegM = 8; RegWriteM = 1;
        #2;
        chk("rst_stallf", StallF, 0);
        chk("rst_flushe", FlushE, 0);
        chk("rst_fwdad", ForwardAD, 1);
        chk("rst_cnt", StallCount, 0);
        chk("rst_busy", MduBusy, 0);
        tick();
        rst_n = 1'b1;
        clr_in();

        // 1. load-use
        MemtoRegE = 1; RtE = 8; RsD = 8;
        #1;
        chk("lw_stallf", StallF, 1);
        chk("lw_stalld", StallD, 1);
        chk("lw_flushe", FlushE, 1);
        tick();
        clr_in();
        chk("lw_cnt1", StallCount, 1);
        MemtoRegE = 1; RtE = 0; RsD = 0;
        #1;
        chk("lw_rt0", StallF, 0);
        tick();
        clr_in();
        chk("lw_cnt_hold", StallCount, 1);

        // branch stall on E-stage writer
        BranchD = 1; RegWriteE = 1; WriteRegE = 5; RtD = 5;
        #1;
        chk("br_stall", StallF, 1);
        tick();
        clr_in();
        chk("br_cnt2", StallCount, 2);

        // 2. forwarding priority
        RegWriteM = 1; RegWriteW = 1; WriteRegM = 9; WriteRegW = 9; RsE = 9; RtE = 9;
        #1;
        chk("fwd_ae_m", ForwardAE, 2'b10);
        chk("fwd_be_m", ForwardBE, 2'b10);
        RegWriteM = 0;
        #1;
        chk("fwd_ae_w", ForwardAE, 2'b01);
        RsE = 0;
        #1;
        chk("fwd_ae_zero", ForwardAE, 2'b00);
        RegWriteM = 1; RtD = 9; RsD = 3;
        #1;
        chk("fwd_bd", ForwardBD, 1);
        chk("fwd_ad_no", ForwardAD, 0);
        clr_in();
        tick();

        // 3. syscall drain through M then W
        SyscallD = 1; RegWriteM = 1; WriteRegM = 2;
        #1;
        chk("sd_c1_stall", StallF, 1);
        chk("sd_c1_go", SyscallGo, 0);
        tick();
        RegWriteM = 0; RegWriteW = 1; WriteRegW = 2;
        #1;
        chk("sd_c2_stall", StallF, 1);
        chk("sd_c2_go", SyscallGo, 0);
        tick();
        RegWriteW = 0;
        #1;
        chk("sd_c3_stall", StallF, 1);
        chk("sd_c3_go", SyscallGo, 0);
        tick();
        chk("sd_c4_stall", StallF, 0);
        chk("sd_c4_go", SyscallGo, 1);
        tick();
        SyscallD = 0;
        #1;
        chk("sd_idle_go", SyscallGo, 0);
        chk("sd_idle_stall", StallF, 0);
        tick();

        // 4. syscall with nothing pending
        SyscallD = 1;
        #1;
        chk("sn_c1_stall", StallF, 1);
        tick();
        chk("sn_c2_go", SyscallGo, 1);
        chk("sn_c2_stall", StallF, 0);
        tick();
        SyscallD = 0;
        #1;
        chk("sn_after_go", SyscallGo, 0);
        tick();
        // same, with a load-use hazard in the GO cycle
        SyscallD = 1;
        #1;
        chk("sl_c1_stall", StallF, 1);
        tick();
        MemtoRegE = 1; RtE = 8; RsD = 8;
        #1;
        chk("sl_c2_go", SyscallGo, 0);
        chk("sl_c2_stall", StallF, 1);
        tick();
        MemtoRegE = 0; RtE = 0; RsD = 0;
        #1;
        chk("sl_c3_go", SyscallGo, 1);
        tick();
        SyscallD = 0;
        #1;
        chk("sl_c4_go", SyscallGo, 0);
        clr_in();
        tick();

        // 5. MDU single issue: busy and stalling for 4 cycles
        MduStartE = 1; MduUseD = 1;
        #1;
        chk("mdu_c0_busy", MduBusy, 0);
        chk("mdu_c0_stall", StallF, 0);
        tick();
        MduStartE = 0;
        for (int i = 1; i <= 5; i++) begin
            chk($sformatf("mdu1_busy_c%0d", i), MduBusy, (i <= 4) ? 1 : 0);
            chk($sformatf("mdu1_stall_c%0d", i), StallF, (i <= 4) ? 1 : 0);
            tick();
        end
        // reissue in cycle 2 extends busy to cycle 6
        MduStartE = 1;
        tick();
        MduStartE = 0;
        for (int i = 1; i <= 7; i++) begin
            if (i == 2) MduStartE = 1;
            #1;
            chk($sformatf("mdu2_busy_c%0d", i), MduBusy, (i <= 6) ? 1 : 0);
            tick();
            MduStartE = 0;
        end
        clr_in();
        tick();

        // 6. reset while draining a syscall
        SyscallD = 1; RegWriteM = 1; WriteRegM = 4;
        tick();
        chk("rd_drain_stall", StallF, 1);
        rst_n = 0;
        #1;
        chk("rd_rst_stall", StallF, 0);
        chk("rd_rst_go", SyscallGo, 0);
        chk("rd_rst_cnt", StallCount, 0);
        tick();
        rst_n = 1;
        clr_in();
        #1;
        chk("rd_post_go", SyscallGo, 0);
        tick();
        chk("rd_post2_go", SyscallGo, 0);
        chk("rd_post2_stall", StallF, 0);

        // clear beats increment, then saturation at CNT_W=4
        MemtoRegE = 1; RtE = 8; RsD = 8; CntClr = 1;
        tick();
        CntClr = 0;
        chk("clr_cnt", StallCount, 0);
        chk("clr_cnt4", StallCount4, 0);
        for (int i = 0; i < 20; i++) tick();
        chk("sat_cnt32", StallCount, 20);
        chk("sat_cnt4", StallCount4, 15);
        clr_in();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
